// File: rtl/brick_row_fetcher.sv
// Fetches one 16-pixel tile row from a 1-cycle-latency ROM into a line buffer, optionally mirrored.
// Optional macro BRICK_TRANSPARENCY_EN: store a per-column colour-key flag and blank keyed pixels.
module brick_row_fetcher #(
  parameter int          TILE_W          = 16,
  parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [3:0]  row,
  input  logic        flip,
  output logic [7:0]  rom_addr,
  input  logic [23:0] rom_data,
  input  logic [3:0]  rd_col,
  output logic [23:0] rd_pixel,
  output logic        rd_transparent,
  output logic        busy,
  output logic        done,
  output logic        row_valid,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a level request sampled only in IDLE; done is a one-cycle
  // pulse after the last buffer write, and row_valid then holds until the next accept.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [3:0] LAST_COL = 4'(TILE_W - 1);

  state_t      state, state_next;
  logic [3:0]  col, col_inc, row_q;
  logic        flip_q;
  logic        accept, issue, last_wr;
  logic        p0_valid, p1_valid;
  logic [3:0]  p0_col, p1_col, wr_idx;
  logic [23:0] pix_mem [TILE_W];

  assign col_inc   = col + 4'd1;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    last_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        issue = 1'b1;
        if (col_inc == LAST_COL) state_next = DRAIN;
      end
      DRAIN: begin
        // Last write happens once only the final column remains in the pipeline.
        if (p1_valid && !p0_valid) begin
          last_wr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      col       <= 4'h0;
      row_q     <= 4'h0;
      flip_q    <= 1'b0;
      rom_addr  <= 8'h00;
      p0_valid  <= 1'b0;
      p0_col    <= 4'h0;
      p1_valid  <= 1'b0;
      p1_col    <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_valid <= 1'b0;
    end else begin
      state    <= state_next;
      done     <= last_wr;
      p0_valid <= accept | issue;
      p1_valid <= p0_valid;
      p1_col   <= p0_col;
      if (accept) begin
        row_q     <= row;
        flip_q    <= flip;
        col       <= 4'h0;
        rom_addr  <= {row, 4'h0};
        p0_col    <= 4'h0;
        busy      <= 1'b1;
        row_valid <= 1'b0;
      end else if (issue) begin
        col      <= col_inc;
        rom_addr <= {row_q, col_inc};
        p0_col   <= col_inc;
      end
      if (last_wr) begin
        busy      <= 1'b0;
        row_valid <= 1'b1;
      end
    end
  end

  // ROM is always read in ascending order; mirroring happens on the write side.
  assign wr_idx = flip_q ? (LAST_COL - p1_col) : p1_col;

`ifdef BRICK_TRANSPARENCY_EN
  logic tr_mem [TILE_W];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TILE_W; i++) begin
        pix_mem[i] <= 24'h0;
        tr_mem[i]  <= 1'b0;
      end
    end else if (p1_valid) begin
      if (rom_data == TRANSPARENT_KEY) begin
        pix_mem[wr_idx] <= 24'h0;
        tr_mem[wr_idx]  <= 1'b1;
      end else begin
        pix_mem[wr_idx] <= rom_data;
        tr_mem[wr_idx]  <= 1'b0;
      end
    end
  end

  assign rd_transparent = tr_mem[rd_col];
`else
  // The colour key only matters when transparency storage is built in.
  logic unused_key_hit;
  assign unused_key_hit = (rom_data == TRANSPARENT_KEY);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < TILE_W; i++) pix_mem[i] <= 24'h0;
    end else if (p1_valid) begin
      pix_mem[wr_idx] <= rom_data;
    end
  end

  assign rd_transparent = 1'b0;
`endif

  assign rd_pixel = pix_mem[rd_col];

endmodule

// File: tb/tb_brick_row_fetcher.sv
// Bench for brick_row_fetcher: timeline-based row-fetch model, per-cycle compare, directed and random stimulus.
module tb_brick_row_fetcher;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  row = 4'h0;
  logic        flip = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = 24'h0;
  logic [3:0]  rd_col = 4'h0;
  logic [23:0] rd_pixel;
  logic        rd_transparent;
  logic        busy, done, row_valid;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] mem [256];

  // Model: a fetch accepted at edge E0 is described purely by edge offset n = edge - E0.
  bit          m_active;
  int          m_n;
  logic [3:0]  m_row;
  bit          m_flip;
  logic [7:0]  m_addr;
  bit          m_busy, m_done, m_valid;
  logic [23:0] m_pix [16];
  bit          m_tr  [16];

  brick_row_fetcher #(.TILE_W(16), .TRANSPARENT_KEY(KEY)) dut (
    .Clk(clk), .Reset(Reset), .start(start), .row(row), .flip(flip),
    .rom_addr(rom_addr), .rom_data(rom_data), .rd_col(rd_col),
    .rd_pixel(rd_pixel), .rd_transparent(rd_transparent),
    .busy(busy), .done(done), .row_valid(row_valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency tile ROM
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_n = 0; m_row = 0; m_flip = 0; m_addr = 8'h00;
    m_busy = 0; m_done = 0; m_valid = 0;
    for (int i = 0; i < 16; i++) begin
      m_pix[i] = 24'h0;
      m_tr[i]  = 0;
    end
  endtask

  task automatic model_write(input int k);
    int          idx;
    logic [3:0]  kk;
    logic [23:0] d;
    kk  = 4'(k);
    idx = m_flip ? 15 - k : k;
    d   = mem[{m_row, kk}];
`ifdef BRICK_TRANSPARENCY_EN
    m_tr[idx]  = (d == KEY);
    m_pix[idx] = (d == KEY) ? 24'h0 : d;
`else
    m_tr[idx]  = 0;
    m_pix[idx] = d;
`endif
  endtask

  task automatic model_step();
    if (Reset) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (m_active) begin
      m_n++;
      if (m_n <= 15) m_addr = {m_row, 4'(m_n)};
      if (m_n >= 2) model_write(m_n - 2);
      if (m_n == 17) begin
        m_active = 0; m_busy = 0; m_valid = 1; m_done = 1;
      end
    end else if (start) begin
      m_active = 1; m_n = 0; m_row = row; m_flip = flip;
      m_addr = {row, 4'h0}; m_valid = 0; m_busy = 1;
    end
  endtask

  // Compare process: every cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("row_valid", 32'(row_valid), 32'(m_valid));
    chk("rd_pixel", 32'(rd_pixel), 32'(m_pix[rd_col]));
    chk("rd_transparent", 32'(rd_transparent), 32'(m_tr[rd_col]));
  end

  // Driver: advance n edges, then sit 2 units after the edge (after the compare).
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [3:0] r, input logic f);
    row = r; flip = f; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(17);
  endtask

  task automatic sweep_pixels(input string name, input logic [3:0] r, input bit f, input bit zero);
    logic [7:0]  b;
    logic [23:0] e;
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c);
      #1;
      b = {r, 4'(f ? 15 - c : c)};
      e = zero ? 24'h0 : {b, b, b};
      chk(name, 32'(rd_pixel), 32'(e));
    end
  endtask

  task automatic init_rom();
    for (int a = 0; a < 256; a++) mem[a] = {8'(a), 8'(a), 8'(a)};
  endtask

  initial begin
    init_rom();
    model_reset();
    #1 Reset = 1'b1;
    #1;
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_valid", 32'(row_valid), 32'h0);
    sweep_pixels("rst_pix", 4'h0, 0, 1);
    cyc(2);
    Reset = 1'b0;

    // Basic fetch, row 3, no mirror; start accepted on the first edge after reset
    row = 4'h3; flip = 1'b0; start = 1'b1;
    cyc(1);
    chk("e0_addr", 32'(rom_addr), 32'h30);
    chk("e0_busy", 32'(busy), 32'h1);
    start = 1'b0;
    cyc(15);
    chk("e15_addr", 32'(rom_addr), 32'h3F);
    cyc(1);
    chk("e16_done", 32'(done), 32'h0);
    chk("e16_busy", 32'(busy), 32'h1);
    cyc(1);
    chk("e17_done", 32'(done), 32'h1);
    chk("e17_busy", 32'(busy), 32'h0);
    chk("e17_valid", 32'(row_valid), 32'h1);
    rd_col = 4'd5;
    #1;
    chk("basic_col5", 32'(rd_pixel), 32'h353535);
    cyc(1);
    chk("e18_done", 32'(done), 32'h0);
    chk("idle_addr", 32'(rom_addr), 32'h3F);
    sweep_pixels("basic_pix", 4'h3, 0, 0);
    cyc(2);

    // Mirror
    fetch(4'h3, 1'b1);
    rd_col = 4'd0;
    #1;
    chk("mirror_col0", 32'(rd_pixel), 32'h3F3F3F);
    rd_col = 4'd15;
    #1;
    chk("mirror_col15", 32'(rd_pixel), 32'h303030);
    sweep_pixels("mirror_pix", 4'h3, 1, 0);
    cyc(2);

    // start held high; row change during the first fetch must not leak in
    row = 4'h3; flip = 1'b0; start = 1'b1;
    cyc(4);
    row = 4'h7;
    cyc(14);
    chk("hold_e17_done", 32'(done), 32'h1);
    chk("hold_e17_addr", 32'(rom_addr), 32'h3F);
    cyc(1);
    chk("hold_e18_addr", 32'(rom_addr), 32'h70);
    chk("hold_e18_busy", 32'(busy), 32'h1);
    start = 1'b0;
    cyc(17);
    chk("hold2_done", 32'(done), 32'h1);
    rd_col = 4'd5;
    #1;
    chk("hold2_col5", 32'(rd_pixel), 32'h757575);
    cyc(2);

    // Mid-fetch reset at E0+9
    row = 4'h3; flip = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(9);
    Reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_valid", 32'(row_valid), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    sweep_pixels("mrst_pix", 4'h0, 0, 1);
    cyc(1);
    Reset = 1'b0;
    cyc(20);
    chk("mrst_after_valid", 32'(row_valid), 32'h0);

    // Colour key at column 2 of row 3
    mem[8'h32] = KEY;
    fetch(4'h3, 1'b0);
    rd_col = 4'd2;
    #1;
`ifdef BRICK_TRANSPARENCY_EN
    chk("key_tr", 32'(rd_transparent), 32'h1);
    chk("key_pix", 32'(rd_pixel), 32'h0);
`else
    chk("key_tr", 32'(rd_transparent), 32'h0);
    chk("key_pix", 32'(rd_pixel), 32'hFF00FF);
`endif
    cyc(2);
    mem[8'h32] = 24'h323232;

    // Random phase: random ROM with scattered keys, random requests, rare resets
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
    repeat (3000) begin
      start  = ($urandom_range(0, 2) == 0);
      row    = 4'($urandom);
      flip   = 1'($urandom);
      rd_col = 4'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
      end else begin
        cyc(1);
      end
    end
    start = 1'b0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
